uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
- Configurable UART receiver. Successor to the fixed 8N1/8N2 receiver.
- Runtime-selectable data length (5..DW_MAX), parity (none/even/odd) and 1 or 2 stop bits.
- Parametrised oversampling ratio and 3-sample majority vote.
- Reports framing, parity, break and overrun status; holds each word under a valid/ready handshake to the register/FIFO layer.

Parameters:
- DW_MAX, 8: maximum data bits per frame (5..9); rx_data width.
- OVS, 16: oversample ticks per bit (8..32, even).
- DIV_W, 16: width of cfg_div.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- cfg_div  in  DIV_W  oversample tick period: one tick every cfg_div+1 clk cycles
- cfg_rxen  in  1  receiver enable
- cfg_dlen  in  4  data bits per frame; clamped to range 5..DW_MAX
- cfg_parity  in  2  00 none, 01 even, 10 odd, 11 treated as none
- cfg_nstop  in  1  0 = one stop bit, 1 = two stop bits
- uart_rxd  in  1  asynchronous serial input, idle high
- rx_valid  out  1  word available
- rx_ready  in  1  consumer accepts word
- rx_data  out  DW_MAX  received word, LSB-aligned, upper unused bits 0
- rx_frame_err  out  1  qualified by rx_valid: a stop bit was sampled 0
- rx_parity_err  out  1  qualified by rx_valid: parity mismatch
- rx_break  out  1  qualified by rx_valid: all data, parity and stop samples 0
- rx_overrun  out  1  one-cycle pulse: a frame completed while rx_valid=1 and rx_ready=0

Behaviour:
- Reset values: rx_valid=0, rx_data=0, all error flags 0, rx_overrun=0, state IDLE, synchroniser=11.
- Input path: uart_rxd passes a 2-flop synchroniser; all logic uses the synchronised value rxs.
- Tick generator:
  - Counts clk cycles to cfg_div and emits a 1-cycle tick on wrap.
  - A tick counter (0..OVS-1) produces sample strobes s_a, s_b, s_c at tick OVS/2-2, OVS/2, OVS/2+2, and bit end at tick OVS-1.
  - Both counters clear while in IDLE with rxs=0.
- Vote: majority of the three samples, registered at each strobe. It is valid at bit end.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START when rxs=0 and cfg_rxen=1.
  - START at bit end: vote=0 -> DATA; vote=1 -> IDLE (glitch rejected, no output).
  - DATA: at each bit end, write vote into shift[bit_cnt], then bit_cnt++. At bit_cnt=dlen-1 go to PARITY if parity is enabled, else STOP.
  - PARITY at bit end: par_err = XOR(data bits, parity bit) XOR odd. Go to STOP.
  - STOP at bit end: any stop sample 0 sets frame_err. Stay for a second bit if cfg_nstop=1, else complete the frame.
- Config latch: cfg_dlen, cfg_parity and cfg_nstop are captured on the IDLE->START transition. Changes mid-frame have no effect until the next frame.
- cfg_rxen deassertion mid-frame: the current frame completes normally; no new start is accepted.
- Completion is at the last stop bit end, and the FSM returns to IDLE in the same cycle:
  - rx_valid=0, or rx_valid=1 with rx_ready=1 in that cycle: load rx_data and the flags; rx_valid=1 next cycle.
  - rx_valid=1 and rx_ready=0: drop the new frame, keep the held word, pulse rx_overrun.
- Handshake:
  - rx_valid falls the cycle after rx_valid&rx_ready.
  - rx_data and the flags are stable while rx_valid=1.
- Latency: rx_valid rises 1 clk after the last stop bit end.
- Break frame: stop sampled 0 gives frame_err=1 and break=1; the word is delivered as 0. The FSM waits in IDLE-hold until rxs=1 before re-arming, so the low line is not taken as a new start.
- Synchronous reset mid-frame aborts with no output, and rx_valid clears.

Decomposition:
- Package uart_cfg_pkg:
  - Parity enum (PAR_NONE, PAR_EVEN, PAR_ODD).
  - rx_state_t enum (IDLE, START, DATA, PARITY, STOP, BRK_WAIT).
  - Constants DW_MIN=5 and the default OVS.
- One sub-module, uart_baud_os: parametrised (OVS, DIV_W) tick and strobe generator with a clear input. It outputs s_a, s_b, s_c and bit_end.

Test Plan:
- cfg_div=3, 8N1, send 0xA5 -> rx_valid after stop; rx_data=0x0A5; all flags 0; 10 bit-times of 64 clk each.
- 7E2 with dlen=7, even parity: send 0x35 with correct parity bit 0, then 0x35 with parity bit 1 -> first word has no error; second has rx_parity_err=1, rx_data=0x35.
- Hold uart_rxd low for 2 bit-times then release -> rx_data=0, rx_frame_err=1, rx_break=1. No second frame until the line is high; then the next 0x55 is received cleanly.
- rx_ready=0; send 0x11 then 0x22 -> rx_data stays 0x11; rx_overrun pulses exactly 1 cycle at the end of the 0x22 frame. After rx_ready, rx_valid drops.
- 3-clk low glitch at OVS tick scale, plus a single-tick-wide flip at sample s_b within a data bit -> glitch rejected with no rx_valid; flipped bit still decoded correctly by the vote.
- Assert rst_n=0 mid-DATA; also change cfg_dlen mid-frame -> reset aborts with rx_valid=0. Without reset, the in-flight frame uses the latched dlen.

Source files
------------

// File: rtl/uart_cfg_pkg.sv
// Shared types and helpers for the configurable UART receiver.
package uart_cfg_pkg;

    localparam int DW_MIN      = 5;
    localparam int OVS_DEFAULT = 16;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK_WAIT
    } rx_state_t;

    // Encoding 11 is reserved and behaves as "no parity".
    function automatic parity_t decode_parity(input logic [1:0] p);
        case (p)
            2'b01:   return PAR_EVEN;
            2'b10:   return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

    // Keeps the requested word length inside DW_MIN..dw_max.
    function automatic logic [3:0] clamp_dlen(input logic [3:0] dlen, input int dw_max);
        logic [3:0] lo;
        logic [3:0] hi;
        lo = 4'(DW_MIN);
        hi = 4'(dw_max);
        if (dlen < lo) return lo;
        if (dlen > hi) return hi;
        return dlen;
    endfunction

endpackage

// File: rtl/uart_baud_os.sv
// Oversample tick generator: divides clk down to ticks, counts OVS ticks per
// bit and emits the three vote strobes plus a bit-end strobe.
module uart_baud_os
    import uart_cfg_pkg::*;
#(
    parameter int OVS   = OVS_DEFAULT,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             s_a,
    output logic             s_b,
    output logic             s_c,
    output logic             bit_end
);

    localparam int TW = $clog2(OVS);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
    logic             tick;

    // >= rather than == so a shrinking cfg_div never forces a full wrap.
    assign tick = (div_cnt_q >= cfg_div);

    // Next-state for the divider and the per-bit tick counter.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        div_cnt_d  = div_cnt_q + 1'b1;
        tick_cnt_d = tick_cnt_q;
        if (clr) begin
            div_cnt_d  = '0;
            tick_cnt_d = '0;
        end else if (tick) begin
            div_cnt_d  = '0;
            tick_cnt_d = (tick_cnt_q == TW'(OVS - 1)) ? '0 : tick_cnt_q + 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
        if (!rst_n) begin
            div_cnt_q  <= '0;
            tick_cnt_q <= '0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    assign s_a     = tick && (tick_cnt_q == TW'(OVS / 2 - 2));
    assign s_b     = tick && (tick_cnt_q == TW'(OVS / 2));
    assign s_c     = tick && (tick_cnt_q == TW'(OVS / 2 + 2));
    assign bit_end = tick && (tick_cnt_q == TW'(OVS - 1));

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..DW_MAX data bits, optional parity, 1 or 2
// stop bits, 3-sample majority vote, and a valid/ready output holding register.
module uart_rx_cfg
    import uart_cfg_pkg::*;
#(
    parameter int DW_MAX = 8,
    parameter int OVS    = OVS_DEFAULT,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              cfg_rxen,
    input  logic [3:0]        cfg_dlen,
    input  logic [1:0]        cfg_parity,
    input  logic              cfg_nstop,
    input  logic              uart_rxd,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic [DW_MAX-1:0] rx_data,
    output logic              rx_frame_err,
    output logic              rx_parity_err,
    output logic              rx_break,
    output logic              rx_overrun
);

    // Synchroniser and vote sample registers.
    logic sync1_q, sync1_d, rxs_q, rxs_d;
    logic sa_q, sa_d, sb_q, sb_d, sc_q, sc_d;

    // Frame FSM state and the configuration latched at frame start.
    rx_state_t         state_q, state_d;
    logic [3:0]        dlen_q, dlen_d;
    parity_t           par_q, par_d;
    logic              nstop_q, nstop_d;
    logic              stop2_q, stop2_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [DW_MAX-1:0] shift_q, shift_d;
    logic              frame_err_q, frame_err_d;
    logic              par_err_q, par_err_d;
    logic              brk_q, brk_d;

    // Output holding register.
    logic              rx_valid_q, rx_valid_d;
    logic [DW_MAX-1:0] rx_data_q, rx_data_d;
    logic              rx_frame_err_q, rx_frame_err_d;
    logic              rx_parity_err_q, rx_parity_err_d;
    logic              rx_break_q, rx_break_d;
    logic              rx_overrun_q, rx_overrun_d;

    logic s_a, s_b, s_c, bit_end, clr, vote;
    logic stop_frame_err, stop_brk;

    // Counters restart on the falling start edge so sampling is centred.
    assign clr = (state_q == IDLE) && !rxs_q;

    uart_baud_os #(
        .OVS   (OVS),
        .DIV_W (DIV_W)
    ) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .cfg_div (cfg_div),
        .s_a     (s_a),
        .s_b     (s_b),
        .s_c     (s_c),
        .bit_end (bit_end)
    );

    assign vote           = (sa_q & sb_q) | (sa_q & sc_q) | (sb_q & sc_q);
    assign stop_frame_err = frame_err_q | ~vote;
    assign stop_brk       = brk_q & ~vote;

    // Synchroniser shift and per-strobe sample capture.
    always_comb begin
        sync1_d = uart_rxd;
        rxs_d   = sync1_q;
        sa_d    = s_a ? rxs_q : sa_q;
        sb_d    = s_b ? rxs_q : sb_q;
        sc_d    = s_c ? rxs_q : sc_q;
    end

    // Frame FSM plus output handshake / overrun decision.
    always_comb begin
        state_d         = state_q;
        dlen_d          = dlen_q;
        par_d           = par_q;
        nstop_d         = nstop_q;
        stop2_d         = stop2_q;
        bit_cnt_d       = bit_cnt_q;
        shift_d         = shift_q;
        frame_err_d     = frame_err_q;
        par_err_d       = par_err_q;
        brk_d           = brk_q;
        rx_valid_d      = rx_valid_q && !rx_ready;
        rx_data_d       = rx_data_q;
        rx_frame_err_d  = rx_frame_err_q;
        rx_parity_err_d = rx_parity_err_q;
        rx_break_d      = rx_break_q;
        rx_overrun_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rxs_q && cfg_rxen) begin
                    state_d     = START;
                    dlen_d      = clamp_dlen(cfg_dlen, DW_MAX);
                    par_d       = decode_parity(cfg_parity);
                    nstop_d     = cfg_nstop;
                    stop2_d     = 1'b0;
                    bit_cnt_d   = '0;
                    shift_d     = '0;
                    frame_err_d = 1'b0;
                    par_err_d   = 1'b0;
                    brk_d       = 1'b1;
                end
            end
            START: begin
                if (bit_end) state_d = vote ? IDLE : DATA;
            end
            DATA: begin
                if (bit_end) begin
                    for (int i = 0; i < DW_MAX; i++) begin
                        if (bit_cnt_q == 4'(i)) shift_d[i] = vote;
                    end
                    brk_d     = brk_q & ~vote;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == dlen_q - 4'd1) begin
                        state_d = (par_q == PAR_NONE) ? STOP : PARITY;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    par_err_d = (^shift_q) ^ vote ^ (par_q == PAR_ODD);
                    brk_d     = brk_q & ~vote;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    frame_err_d = stop_frame_err;
                    brk_d       = stop_brk;
                    if (nstop_q && !stop2_q) begin
                        stop2_d = 1'b1;
                    end else begin
                        // A break leaves the line low; hold off re-arming until it idles.
                        state_d = stop_brk ? BRK_WAIT : IDLE;
                        if (!rx_valid_q || rx_ready) begin
                            rx_valid_d      = 1'b1;
                            rx_data_d       = shift_q;
                            rx_frame_err_d  = stop_frame_err;
                            rx_parity_err_d = par_err_q;
                            rx_break_d      = stop_brk;
                        end else begin
                            rx_overrun_d = 1'b1;
                        end
                    end
                end
            end
            BRK_WAIT: begin
                if (rxs_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // All receiver registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q         <= 1'b1;
            rxs_q           <= 1'b1;
            sa_q            <= 1'b1;
            sb_q            <= 1'b1;
            sc_q            <= 1'b1;
            state_q         <= IDLE;
            dlen_q          <= 4'(DW_MAX);
            par_q           <= PAR_NONE;
            nstop_q         <= 1'b0;
            stop2_q         <= 1'b0;
            bit_cnt_q       <= '0;
            // NOTE: the shift register is a handful of flops, not a RAM, so it is reset like the rest.
            shift_q         <= '0;
            frame_err_q     <= 1'b0;
            par_err_q       <= 1'b0;
            brk_q           <= 1'b0;
            rx_valid_q      <= 1'b0;
            rx_data_q       <= '0;
            rx_frame_err_q  <= 1'b0;
            rx_parity_err_q <= 1'b0;
            rx_break_q      <= 1'b0;
            rx_overrun_q    <= 1'b0;
        end else begin
            sync1_q         <= sync1_d;
            rxs_q           <= rxs_d;
            sa_q            <= sa_d;
            sb_q            <= sb_d;
            sc_q            <= sc_d;
            state_q         <= state_d;
            dlen_q          <= dlen_d;
            par_q           <= par_d;
            nstop_q         <= nstop_d;
            stop2_q         <= stop2_d;
            bit_cnt_q       <= bit_cnt_d;
            shift_q         <= shift_d;
            frame_err_q     <= frame_err_d;
            par_err_q       <= par_err_d;
            brk_q           <= brk_d;
            rx_valid_q      <= rx_valid_d;
            rx_data_q       <= rx_data_d;
            rx_frame_err_q  <= rx_frame_err_d;
            rx_parity_err_q <= rx_parity_err_d;
            rx_break_q      <= rx_break_d;
            rx_overrun_q    <= rx_overrun_d;
        end
    end

    assign rx_valid      = rx_valid_q;
    assign rx_data       = rx_data_q;
    assign rx_frame_err  = rx_frame_err_q;
    assign rx_parity_err = rx_parity_err_q;
    assign rx_break      = rx_break_q;
    assign rx_overrun    = rx_overrun_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: cfg_div=3, OVS=16 -> 64 clk per bit.
module tb_uart_rx_cfg;

    localparam int BIT_CLK = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cfg_div;
    logic        cfg_rxen;
    logic [3:0]  cfg_dlen;
    logic [1:0]  cfg_parity;
    logic        cfg_nstop;
    logic        uart_rxd;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        rx_frame_err;
    logic        rx_parity_err;
    logic        rx_break;
    logic        rx_overrun;

    int n_cmp = 0;
    int n_err = 0;
    int ovr_cnt = 0;
    int vld_cnt = 0;
    int snap;

    uart_rx_cfg #(.DW_MAX(8), .OVS(16), .DIV_W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_div       (cfg_div),
        .cfg_rxen      (cfg_rxen),
        .cfg_dlen      (cfg_dlen),
        .cfg_parity    (cfg_parity),
        .cfg_nstop     (cfg_nstop),
        .uart_rxd      (uart_rxd),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_data       (rx_data),
        .rx_frame_err  (rx_frame_err),
        .rx_parity_err (rx_parity_err),
        .rx_break      (rx_break),
        .rx_overrun    (rx_overrun)
    );

    always #5 clk = ~clk;

    // Counts overrun pulse cycles and cycles with a word held.
    always @(negedge clk) begin
        if (rx_overrun) ovr_cnt++;
        if (rx_valid)   vld_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sends bits[0..nbits-1] LSB first; frame bit flip_idx is inverted for
    // one tick (4 clk) around its s_b sample point only.
    task automatic send_frame(input logic [15:0] bits, input int nbits, input int flip_idx);
        for (int i = 0; i < nbits; i++) begin
            for (int c = 0; c < BIT_CLK; c++) begin
                uart_rxd = (i == flip_idx && c >= 34 && c < 38) ? ~bits[i] : bits[i];
                @(negedge clk);
            end
        end
        uart_rxd = 1'b1;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        for (int i = 0; i < budget && !rx_valid; i++) @(negedge clk);
        check(tag, {31'd0, rx_valid}, 32'd1);
    endtask

    task automatic accept(input string tag);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check(tag, {31'd0, rx_valid}, 32'd0);
    endtask

    task automatic check_word(input string tag, input logic [7:0] d, input logic fe,
                              input logic pe, input logic brk);
        check({tag, "_data"}, {24'd0, rx_data}, {24'd0, d});
        check({tag, "_ferr"}, {31'd0, rx_frame_err}, {31'd0, fe});
        check({tag, "_perr"}, {31'd0, rx_parity_err}, {31'd0, pe});
        check({tag, "_brk"}, {31'd0, rx_break}, {31'd0, brk});
    endtask

    initial begin
        rst_n      = 1'b0;
        cfg_div    = 16'd3;
        cfg_rxen   = 1'b1;
        cfg_dlen   = 4'd8;
        cfg_parity = 2'b00;
        cfg_nstop  = 1'b0;
        uart_rxd   = 1'b1;
        rx_ready   = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state.
        check_word("rst", 8'h00, 1'b0, 1'b0, 1'b0);
        check("rst_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_ovr", {31'd0, rx_overrun}, 32'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // 8N1 0xA5: valid must rise exactly 3 clk after the stop bit is sent.
        send_frame({6'd0, 1'b1, 8'hA5, 1'b0}, 10, -1);
        repeat (2) @(negedge clk);
        check("a5_early", {31'd0, rx_valid}, 32'd0);
        @(negedge clk);
        check("a5_valid", {31'd0, rx_valid}, 32'd1);
        check_word("a5", 8'hA5, 1'b0, 1'b0, 1'b0);
        accept("a5_drop");
        repeat (10) @(negedge clk);

        // 7E2: 0x35 has four ones, so even parity bit is 0.
        cfg_dlen = 4'd7; cfg_parity = 2'b01; cfg_nstop = 1'b1;
        send_frame({5'd0, 2'b11, 1'b0, 7'h35, 1'b0}, 11, -1);
        wait_valid("7e2a_valid", 200);
        check_word("7e2a", 8'h35, 1'b0, 1'b0, 1'b0);
        accept("7e2a_drop");
        repeat (10) @(negedge clk);
        send_frame({5'd0, 2'b11, 1'b1, 7'h35, 1'b0}, 11, -1);
        wait_valid("7e2b_valid", 200);
        check_word("7e2b", 8'h35, 1'b0, 1'b1, 1'b0);
        accept("7e2b_drop");
        repeat (10) @(negedge clk);

        // dlen=3 clamps to 5; odd parity, 0x16 has three ones -> parity bit 0.
        cfg_dlen = 4'd3; cfg_parity = 2'b10; cfg_nstop = 1'b0;
        send_frame({8'd0, 1'b1, 1'b0, 5'h16, 1'b0}, 8, -1);
        wait_valid("clamp_valid", 200);
        check_word("clamp", 8'h16, 1'b0, 1'b0, 1'b0);
        accept("clamp_drop");
        cfg_dlen = 4'd8; cfg_parity = 2'b00;
        repeat (10) @(negedge clk);

        // Break: line low much longer than a frame; no re-arm while low.
        uart_rxd = 1'b0;
        wait_valid("brk_valid", 800);
        check_word("brk", 8'h00, 1'b1, 1'b0, 1'b1);
        accept("brk_drop");
        snap = vld_cnt;
        repeat (800) @(negedge clk);
        check("brk_hold", vld_cnt - snap, 0);
        uart_rxd = 1'b1;
        repeat (128) @(negedge clk);
        send_frame({6'd0, 1'b1, 8'h55, 1'b0}, 10, -1);
        wait_valid("post_brk_valid", 200);
        check_word("post_brk", 8'h55, 1'b0, 1'b0, 1'b0);
        accept("post_brk_drop");
        repeat (10) @(negedge clk);

        // Overrun: 0x11 held, 0x22 dropped, one overrun cycle.
        send_frame({6'd0, 1'b1, 8'h11, 1'b0}, 10, -1);
        wait_valid("ovr1_valid", 200);
        snap = ovr_cnt;
        repeat (10) @(negedge clk);
        send_frame({6'd0, 1'b1, 8'h22, 1'b0}, 10, -1);
        repeat (10) @(negedge clk);
        check("ovr_valid", {31'd0, rx_valid}, 32'd1);
        check("ovr_data", {24'd0, rx_data}, 32'h11);
        check("ovr_pulses", ovr_cnt - snap, 1);
        accept("ovr_drop");
        repeat (10) @(negedge clk);

        // 3-clk glitch: rejected, nothing delivered.
        snap = vld_cnt;
        uart_rxd = 1'b0;
        repeat (3) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (150) @(negedge clk);
        check("glitch_none", vld_cnt - snap, 0);

        // 0x3C with data bit 2 (frame bit 3) flipped at s_b only.
        send_frame({6'd0, 1'b1, 8'h3C, 1'b0}, 10, 3);
        wait_valid("flip_valid", 200);
        check_word("flip", 8'h3C, 1'b0, 1'b0, 1'b0);
        accept("flip_drop");
        repeat (10) @(negedge clk);

        // dlen change mid-frame has no effect on the frame in flight.
        fork
            send_frame({6'd0, 1'b1, 8'hA5, 1'b0}, 10, -1);
            begin
                repeat (200) @(negedge clk);
                cfg_dlen = 4'd5;
            end
        join
        wait_valid("latch_valid", 200);
        check_word("latch", 8'hA5, 1'b0, 1'b0, 1'b0);
        accept("latch_drop");
        cfg_dlen = 4'd8;
        repeat (10) @(negedge clk);

        // Reset mid-DATA with a word held: aborts and clears rx_valid.
        send_frame({6'd0, 1'b1, 8'h33, 1'b0}, 10, -1);
        wait_valid("pre_rst_valid", 200);
        repeat (10) @(negedge clk);
        send_frame({12'd0, 3'b101, 1'b0}, 4, -1);
        cfg_dlen = 4'd6;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mid_valid", {31'd0, rx_valid}, 32'd0);
        rst_n = 1'b1;
        cfg_dlen = 4'd8;
        snap = vld_cnt;
        repeat (700) @(negedge clk);
        check("rst_mid_none", vld_cnt - snap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
